rms_frame_packer: RTL and testbench

Consumer end of the RMSER_8 result interface. On each DATA_READY rising edge it snapshots RMS1..RMS8 and serialises them as a byte frame over a valid/ready byte stream toward the host link (UART/USB TX). It sits between RMSER_8 and the host transmit FIFO, decimates the frame rate, and counts frames it had to drop.

---
 rtl/rms_pack_pkg.sv | 26 ++
 rtl/rise_detect.sv | 21 ++
 rtl/rms_frame_packer.sv | 158 +++++++++++++++
 tb/tb_rms_frame_packer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rms_pack_pkg.sv
// rtl/rms_pack_pkg.sv - shared state type and frame sizes for rms_frame_packer (frame length set by RMS_PACK_CHECKSUM_EN)
package rms_pack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    COUNT,
    PAYLOAD,
    CHECK
  } pack_state_t;

  localparam int NUM_CH        = 8;
  localparam int PAYLOAD_BYTES = 16;

`ifdef RMS_PACK_CHECKSUM_EN
  localparam int FRAME_LEN = 19;
`else
  localparam int FRAME_LEN = 18;
`endif

  // Payload is sent big-endian per channel: even index = MSB, odd index = LSB.
  function automatic logic [7:0] payload_byte(input logic [15:0] word, input logic lsb);
    return lsb ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector with selectable reset level
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember the previous level; a high reset value suppresses an edge when din is already high at release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= RESET_VAL;
    else     din_q <= din;
  end

  assign rise = din && !din_q;

endmodule

// File: rtl/rms_frame_packer.sv
// rtl/rms_frame_packer.sv - snapshots RMS1..RMS8 on DATA_READY and streams them as a byte frame (checksum byte when RMS_PACK_CHECKSUM_EN)
module rms_frame_packer
  import rms_pack_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         DECIMATION  = 1
) (
  input  logic        M_CLK,
  input  logic        RESET,
  input  logic        DATA_READY,
  input  logic [15:0] RMS1,
  input  logic [15:0] RMS2,
  input  logic [15:0] RMS3,
  input  logic [15:0] RMS4,
  input  logic [15:0] RMS5,
  input  logic [15:0] RMS6,
  input  logic [15:0] RMS7,
  input  logic [15:0] RMS8,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        BUSY,
  output logic [7:0]  DROP_COUNT
);

  localparam logic [7:0] DEC_LAST = 8'(DECIMATION - 1);
  localparam logic [3:0] IDX_LAST = 4'(PAYLOAD_BYTES - 1);

  pack_state_t state, state_nxt;
  logic [3:0]  byte_idx, byte_idx_nxt;
  logic [7:0]  dec_cnt;
  logic [7:0]  frame_cnt;
  logic [7:0]  drop_cnt;
  logic [15:0] rms_in [NUM_CH];
  logic [15:0] snap   [NUM_CH];
  logic        dr_rise;
  logic        send_req;
  logic        hs;
  logic        last_hs;
`ifdef RMS_PACK_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign rms_in[0] = RMS1;
  assign rms_in[1] = RMS2;
  assign rms_in[2] = RMS3;
  assign rms_in[3] = RMS4;
  assign rms_in[4] = RMS5;
  assign rms_in[5] = RMS6;
  assign rms_in[6] = RMS7;
  assign rms_in[7] = RMS8;

  rise_detect #(.RESET_VAL(1'b1)) u_dr_rise (
    .clk  (M_CLK),
    .rst  (RESET),
    .din  (DATA_READY),
    .rise (dr_rise)
  );

  assign send_req   = dr_rise && (dec_cnt == DEC_LAST);
  assign hs         = TX_VALID && TX_READY;
  assign BUSY       = (state != IDLE);
  assign DROP_COUNT = drop_cnt;

  // Count accepted edges; only the edge that wraps the counter becomes a send request.
  always_ff @(posedge M_CLK or posedge RESET) begin
    if (RESET)        dec_cnt <= 8'd0;
    else if (dr_rise) dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
  end

  // Snapshot the channels only when a frame can start, so a frame in flight is never disturbed.
  always_ff @(posedge M_CLK) begin
    if (send_req && state == IDLE) snap <= rms_in;
  end

  // Requests arriving while a frame is in flight are counted, saturating at 255.
  always_ff @(posedge M_CLK or posedge RESET) begin
    if (RESET)                                              drop_cnt <= 8'd0;
    else if (send_req && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  // Frame sequence number advances once the final byte of a frame is accepted.
  always_ff @(posedge M_CLK or posedge RESET) begin
    if (RESET)        frame_cnt <= 8'd0;
    else if (last_hs) frame_cnt <= frame_cnt + 8'd1;
  end

`ifdef RMS_PACK_CHECKSUM_EN
  // Running sum of every byte accepted before the checksum byte; cleared between frames.
  always_ff @(posedge M_CLK or posedge RESET) begin
    if (RESET)                      csum <= 8'd0;
    else if (state == IDLE)         csum <= 8'd0;
    else if (hs && state != CHECK)  csum <= csum + TX_DATA;
  end
`endif

  // State and payload index registers.
  always_ff @(posedge M_CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      byte_idx <= 4'd0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  // Next-state and byte mux; outputs depend only on state so they hold while TX_READY is low.
  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    TX_VALID     = (state != IDLE);
    TX_DATA      = 8'h00;
    last_hs      = 1'b0;
    case (state)
      IDLE: begin
        byte_idx_nxt = 4'd0;
        if (send_req) state_nxt = HEADER;
      end
      HEADER: begin
        TX_DATA = HEADER_BYTE;
        if (hs) state_nxt = COUNT;
      end
      COUNT: begin
        TX_DATA = frame_cnt;
        if (hs) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        TX_DATA = payload_byte(snap[byte_idx[3:1]], byte_idx[0]);
        if (hs) begin
          if (byte_idx == IDX_LAST) begin
`ifdef RMS_PACK_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = IDLE;
            last_hs   = 1'b1;
`endif
          end else begin
            byte_idx_nxt = byte_idx + 4'd1;
          end
        end
      end
      CHECK: begin
`ifdef RMS_PACK_CHECKSUM_EN
        TX_DATA = csum;
        if (hs) begin
          state_nxt = IDLE;
          last_hs   = 1'b1;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rms_frame_packer.sv
// tb/tb_rms_frame_packer.sv - self-checking bench for rms_frame_packer (honours RMS_PACK_CHECKSUM_EN)
module tb_rms_frame_packer;

`ifdef RMS_PACK_CHECKSUM_EN
  localparam int EXP_LEN = 19;
`else
  localparam int EXP_LEN = 18;
`endif

  logic        M_CLK = 1'b0;
  logic        RESET;
  logic        DATA_READY;
  logic        TX_READY;
  logic [15:0] rms [8];

  logic [7:0]  d0_data, d1_data, d0_drop, d1_drop;
  logic        d0_valid, d1_valid, d0_busy, d1_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 M_CLK = ~M_CLK;

  rms_frame_packer #(.HEADER_BYTE(8'hA5), .DECIMATION(1)) dut0 (
    .M_CLK(M_CLK), .RESET(RESET), .DATA_READY(DATA_READY),
    .RMS1(rms[0]), .RMS2(rms[1]), .RMS3(rms[2]), .RMS4(rms[3]),
    .RMS5(rms[4]), .RMS6(rms[5]), .RMS7(rms[6]), .RMS8(rms[7]),
    .TX_DATA(d0_data), .TX_VALID(d0_valid), .TX_READY(TX_READY),
    .BUSY(d0_busy), .DROP_COUNT(d0_drop)
  );

  rms_frame_packer #(.HEADER_BYTE(8'hA5), .DECIMATION(3)) dut1 (
    .M_CLK(M_CLK), .RESET(RESET), .DATA_READY(DATA_READY),
    .RMS1(rms[0]), .RMS2(rms[1]), .RMS3(rms[2]), .RMS4(rms[3]),
    .RMS5(rms[4]), .RMS6(rms[5]), .RMS7(rms[6]), .RMS8(rms[7]),
    .TX_DATA(d1_data), .TX_VALID(d1_valid), .TX_READY(TX_READY),
    .BUSY(d1_busy), .DROP_COUNT(d1_drop)
  );

  // Reference model: one pending frame per instance held as a byte array with a read position.
  logic [7:0] m_fr   [2][19];
  int         m_len  [2] = '{0, 0};
  int         m_pos  [2] = '{0, 0};
  logic [7:0] m_fc   [2] = '{8'd0, 8'd0};
  int         m_dec  [2] = '{0, 0};
  logic [7:0] m_drop [2] = '{8'd0, 8'd0};
  logic       m_prev [2] = '{1'b1, 1'b1};

  logic [7:0] got0 [$];
  logic [7:0] got1 [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dec_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_step(input int i);
    bit busy_b, rise, req;
    int s;
    busy_b = m_pos[i] < m_len[i];
    if (busy_b && TX_READY) begin
      m_pos[i]++;
      if (m_pos[i] == m_len[i]) m_fc[i] = m_fc[i] + 8'd1;
    end
    rise = DATA_READY && !m_prev[i];
    m_prev[i] = DATA_READY;
    req = 0;
    if (rise) begin
      if (m_dec[i] == dec_of(i) - 1) begin m_dec[i] = 0; req = 1; end
      else m_dec[i]++;
    end
    if (req) begin
      if (busy_b) begin
        if (m_drop[i] != 8'hFF) m_drop[i] = m_drop[i] + 8'd1;
      end else begin
        m_fr[i][0] = 8'hA5;
        m_fr[i][1] = m_fc[i];
        for (int k = 0; k < 8; k++) begin
          m_fr[i][2 + 2 * k] = rms[k][15:8];
          m_fr[i][3 + 2 * k] = rms[k][7:0];
        end
        s = 0;
        for (int j = 0; j < 18; j++) s += m_fr[i][j];
        m_fr[i][18] = 8'(s);
        m_len[i] = EXP_LEN;
        m_pos[i] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge M_CLK or posedge RESET);
      for (int i = 0; i < 2; i++) begin
        if (RESET) begin
          m_len[i] = 0; m_pos[i] = 0; m_fc[i] = 8'd0;
          m_dec[i] = 0; m_drop[i] = 8'd0; m_prev[i] = 1'b1;
        end else begin
          model_step(i);
        end
      end
    end
  end

  // Per-cycle comparison against the model, byte capture and stall-stability check.
  logic       st_prev = 1'b0;
  logic [7:0] st_data = 8'h00;
  initial begin
    logic       ev;
    logic [7:0] ed;
    forever begin
      @(negedge M_CLK);
      ev = m_pos[0] < m_len[0];
      ed = ev ? m_fr[0][m_pos[0]] : 8'h00;
      check("d0_valid", d0_valid, ev);
      check("d0_data",  d0_data,  ed);
      check("d0_busy",  d0_busy,  ev);
      check("d0_drop",  d0_drop,  m_drop[0]);
      ev = m_pos[1] < m_len[1];
      ed = ev ? m_fr[1][m_pos[1]] : 8'h00;
      check("d1_valid", d1_valid, ev);
      check("d1_data",  d1_data,  ed);
      check("d1_busy",  d1_busy,  ev);
      check("d1_drop",  d1_drop,  m_drop[1]);
      if (st_prev && !RESET) begin
        check("stall_valid_hold", d0_valid, 1'b1);
        check("stall_data_hold",  d0_data,  st_data);
      end
      st_prev = d0_valid && !TX_READY && !RESET;
      st_data = d0_data;
      if (d0_valid && TX_READY) got0.push_back(d0_data);
      if (d1_valid && TX_READY) got1.push_back(d1_data);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge M_CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    cyc(2);
    RESET = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_dr();
    DATA_READY = 1'b1;
    cyc(1);
    DATA_READY = 1'b0;
  endtask

  // Frame for RMS1=1234, all others zero: A5 00 12 34, fourteen 00, then EB.
  task automatic check_literal(input string nm);
    logic [7:0] exp_b;
    check({nm, "_len"}, got0.size(), EXP_LEN);
    for (int j = 0; j < EXP_LEN; j++) begin
      case (j)
        0:       exp_b = 8'hA5;
        2:       exp_b = 8'h12;
        3:       exp_b = 8'h34;
        18:      exp_b = 8'hEB;
        default: exp_b = 8'h00;
      endcase
      check($sformatf("%s_byte%0d", nm, j), (j < got0.size()) ? got0[j] : 8'hXX, exp_b);
    end
  endtask

  initial begin
    RESET = 1'b1; DATA_READY = 1'b1; TX_READY = 1'b1;
    for (int k = 0; k < 8; k++) rms[k] = 16'h0000;
    cyc(3);
    check("rst_valid", d0_valid, 1'b0);
    check("rst_data",  d0_data,  8'h00);
    check("rst_busy",  d0_busy,  1'b0);
    check("rst_drop",  d0_drop,  8'h00);

    // DATA_READY already high when reset releases: no frame.
    RESET = 1'b0;
    cyc(8);
    check("dr_high_release_d0", d0_busy, 1'b0);
    check("dr_high_release_d1", d1_busy, 1'b0);
    DATA_READY = 1'b0;
    cyc(2);

    // Frame content and latency.
    pulse_reset();
    got0.delete();
    rms[0] = 16'h1234;
    DATA_READY = 1'b1;
    check("pre_edge_valid", d0_valid, 1'b0);
    cyc(1);
    DATA_READY = 1'b0;
    check("latency_valid", d0_valid, 1'b1);
    check("latency_data",  d0_data,  8'hA5);
    cyc(25);
    check_literal("content");
    check("model_pin_cksum", m_fr[0][18], 8'hEB);

    // Same frame under random backpressure.
    pulse_reset();
    got0.delete();
    pulse_dr();
    repeat (80) begin
      TX_READY = 1'($urandom_range(0, 1));
      cyc(1);
    end
    TX_READY = 1'b1;
    cyc(25);
    check_literal("backpressure");

    // Drop while stalled: second snapshot never emitted.
    pulse_reset();
    got0.delete();
    TX_READY = 1'b0;
    rms[0] = 16'hABCD;
    pulse_dr(); cyc(2);
    rms[0] = 16'h5678;
    pulse_dr(); cyc(2);
    check("drop_count", d0_drop, 8'd1);
    check("drop_busy",  d0_busy, 1'b1);
    TX_READY = 1'b1;
    cyc(25);
    check("drop_len",     got0.size(), EXP_LEN);
    check("drop_ch1_msb", got0[2], 8'hAB);
    check("drop_ch1_lsb", got0[3], 8'hCD);

    // Decimation by 3 on dut1.
    pulse_reset();
    got1.delete();
    for (int p = 1; p <= 6; p++) begin
      rms[0] = 16'(p * 16'h0101);
      pulse_dr();
      cyc(24);
    end
    check("dec_len",   got1.size(), 2 * EXP_LEN);
    check("dec_cnt0",  got1[1], 8'h00);
    check("dec_cnt1",  got1[EXP_LEN + 1], 8'h01);
    check("dec_snap0", got1[2], 8'h03);
    check("dec_snap1", got1[EXP_LEN + 2], 8'h06);

    // Reset at payload byte 5 aborts the frame and clears the counter.
    pulse_reset();
    got0.delete();
    rms[0] = 16'h0F0F;
    pulse_dr(); cyc(25);
    pulse_dr(); cyc(7);
    check("abort_sent", got0.size(), EXP_LEN + 7);
    RESET = 1'b1;
    #1;
    check("abort_valid", d0_valid, 1'b0);
    check("abort_busy",  d0_busy,  1'b0);
    cyc(2);
    RESET = 1'b0;
    cyc(1);
    got0.delete();
    pulse_dr(); cyc(25);
    check("post_abort_len", got0.size(), EXP_LEN);
    check("post_abort_cnt", got0[1], 8'h00);

    // Frame counter wrap over 257 frames.
    pulse_reset();
    got0.delete();
    for (int f = 0; f < 257; f++) begin
      for (int k = 0; k < 8; k++) rms[k] = 16'($urandom);
      pulse_dr();
      cyc(EXP_LEN + 3);
    end
    check("wrap_len",    got0.size(), 257 * EXP_LEN);
    check("wrap_cnt1",   got0[EXP_LEN + 1], 8'h01);
    check("wrap_cnt255", got0[255 * EXP_LEN + 1], 8'hFF);
    check("wrap_cnt256", got0[256 * EXP_LEN + 1], 8'h00);

    // Drop counter saturation.
    pulse_reset();
    TX_READY = 1'b0;
    repeat (300) begin
      pulse_dr();
      cyc(1);
    end
    check("drop_sat_d0", d0_drop, 8'd255);
    check("drop_d1",     d1_drop, 8'd99);
    TX_READY = 1'b1;
    cyc(25);

    // Random traffic with occasional resets, checked against the model every cycle.
    pulse_reset();
    repeat (3000) begin
      DATA_READY = ($urandom_range(0, 3) == 0);
      TX_READY   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rms[$urandom_range(0, 7)] = 16'($urandom);
      RESET = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    RESET = 1'b0;
    DATA_READY = 1'b0;
    TX_READY = 1'b1;
    cyc(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
